uart_tx_arbiter: RTL and testbench

- Shares one Uart8 transmitter between NUM_REQ byte-producing requesters using round-robin arbitration.
- Sequences the Uart8 tx handshake (txEn/txStart/txIn, txBusy/txDone) one byte per grant.
- Returns per-requester accept and completion pulses.
- Sits between the application byte sources and the Uart8 tx interface.

---
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one Uart8 transmitter between NUM_REQ byte sources.
//
// Ports:
//   clk, rstN            clock, asynchronous active-low reset
//   enable               arbiter enable, passed straight through to uTxEn
//   reqValid / reqData   per-requester byte-available flag and byte (slice i = [8i+7:8i])
//   reqReady             one-cycle pulse: the requester's byte has been latched
//   reqDone              one-cycle pulse: the requester's byte has been fully transmitted
//   grantId              current or last owner index
//   errPulse             one-cycle pulse when a frame is aborted (start timeout or enable drop)
//   uTxEn/uTxStart/uTxIn Uart8 transmit controls
//   uTxBusy/uTxDone      Uart8 transmit status
//
// Build option: define UART_ARB_BURST_EN to let one owner send up to MAX_BURST
// consecutive bytes before the grant rotates; without it, one byte per grant.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 1024,
    parameter int MAX_BURST     = 4
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       enable,
    input  logic [NUM_REQ-1:0]         reqValid,
    input  logic [8*NUM_REQ-1:0]       reqData,
    output logic [NUM_REQ-1:0]         reqReady,
    output logic [NUM_REQ-1:0]         reqDone,
    output logic [$clog2(NUM_REQ)-1:0] grantId,
    output logic                       errPulse,
    output logic                       uTxEn,
    output logic                       uTxStart,
    output logic [7:0]                 uTxIn,
    input  logic                       uTxBusy,
    input  logic                       uTxDone
);
    localparam int IDW = $clog2(NUM_REQ);
    // Counter wide enough for both the start timeout and the burst length.
    localparam int CW  = $clog2((START_TIMEOUT > MAX_BURST ? START_TIMEOUT : MAX_BURST) + 1);

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     last_q, grant_q, win, rr_idx, sel;
    logic [CW-1:0]      cnt_q;
    logic [7:0]         txin_q;
    logic [NUM_REQ-1:0] ready_q;
    logic               err_q;
    logic               busy_q, busy_p_q, done_q, done_p_q;
    logic               fin_det, timeout, take, reload, abort, burst_go;

    // Frame end is whichever comes first: txDone rising or txBusy falling.
    assign fin_det = (done_q & ~done_p_q) | (busy_p_q & ~busy_q);
    assign timeout = cnt_q == CW'(START_TIMEOUT - 1);
    assign take    = (state_q == IDLE) && enable && (|reqValid);
    assign reload  = take || (state_q == DONE && burst_go);
    assign sel     = (state_q == IDLE) ? win : grant_q;
    assign abort   = (state_q == START && (!enable || (!busy_q && timeout))) ||
                     (state_q == BUSY && !enable);

    // Scan from the farthest candidate down so the nearest valid index after last_q wins.
    always_comb begin
        win    = '0;
        rr_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            rr_idx = IDW'((int'(last_q) + k) % NUM_REQ);
            if (reqValid[rr_idx]) win = rr_idx;
        end
    end

`ifdef UART_ARB_BURST_EN
    logic [CW-1:0] bcnt_q;

    assign burst_go = enable && reqValid[grant_q] && (bcnt_q < CW'(MAX_BURST));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) bcnt_q <= '0;
        else       bcnt_q <= take ? CW'(1) : (state_q == DONE && burst_go) ? bcnt_q + CW'(1) : bcnt_q;
    end
`else
    assign burst_go = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = take ? START : IDLE;
            START:   state_d = !enable ? IDLE : busy_q ? BUSY : timeout ? IDLE : START;
            BUSY:    state_d = !enable ? IDLE : fin_det ? DONE : BUSY;
            default: state_d = burst_go ? START : IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            last_q   <= IDW'(NUM_REQ - 1);
            grant_q  <= '0;
            txin_q   <= '0;
            ready_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            busy_p_q <= 1'b0;
            done_q   <= 1'b0;
            done_p_q <= 1'b0;
        end else begin
            busy_q   <= uTxBusy;
            busy_p_q <= busy_q;
            done_q   <= uTxDone;
            done_p_q <= done_q;
            cnt_q    <= (state_q == START) ? cnt_q + CW'(1) : '0;
            ready_q  <= reload ? NUM_REQ'(1) << sel : '0;
            err_q    <= abort;
            if (reload) begin
                grant_q <= sel;
                txin_q  <= reqData[8*sel +: 8];
            end
            // Every way back to IDLE (done, timeout, abort) moves the pointer past the owner.
            if (state_q != IDLE && state_d == IDLE) last_q <= grant_q;
        end
    end

    always_comb begin
        uTxEn    = enable;
        uTxStart = state_q == START;
        uTxIn    = txin_q;
        reqReady = ready_q;
        reqDone  = (state_q == DONE) ? NUM_REQ'(1) << grant_q : '0;
        grantId  = grant_q;
        errPulse = err_q;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with a transaction-level arbiter model for uart_tx_arbiter.
module tb_uart_tx_arbiter;
    localparam int TIMEOUT = 16;
    localparam int MAXB    = 2;
`ifdef UART_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  reqValid = '0;
    logic [31:0] reqData = '0;
    logic [3:0]  reqReady, reqDone;
    logic [1:0]  grantId;
    logic        errPulse, uTxEn, uTxStart;
    logic [7:0]  uTxIn;
    logic        uTxBusy = 1'b0;
    logic        uTxDone = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    bit uart_never = 1'b0;
    int uart_fin_cnt = 0;
    int err_seen = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .START_TIMEOUT(TIMEOUT), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rstN(rstN), .enable(enable), .reqValid(reqValid), .reqData(reqData),
        .reqReady(reqReady), .reqDone(reqDone), .grantId(grantId), .errPulse(errPulse),
        .uTxEn(uTxEn), .uTxStart(uTxStart), .uTxIn(uTxIn), .uTxBusy(uTxBusy), .uTxDone(uTxDone)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic bit bit_of(input logic [3:0] v, input int i);
        logic [3:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] d, input int i);
        logic [31:0] t;
        t = d >> (8 * i);
        return t[7:0];
    endfunction

    function automatic int rr(input logic [3:0] v, input int last);
        int r;
        r = -1;
        for (int k = 4; k >= 1; k--) if (bit_of(v, (last + k) % 4)) r = (last + k) % 4;
        return r;
    endfunction

    // Uart8 stand-in: busy for 10 cycles per start, then busy falls with a done pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (uTxStart && !uart_never) begin
                @(posedge clk); #1 uTxBusy = 1'b1;
                repeat (10) @(posedge clk);
                #1 uTxBusy = 1'b0; uTxDone = 1'b1; uart_fin_cnt++;
                @(posedge clk); #1 uTxDone = 1'b0;
            end
        end
    end

    // Transaction-level model: who must be granted, what byte must be on the wire, and
    // which completion/abort pulses are legal, checked every cycle.
    initial begin
        int m_last, m_owner, m_bytes, m_start_cyc, m_fin_mark, e;
        bit m_fly, m_en_drop, m_done_prev, cont;
        logic [7:0] m_byte;
        logic [3:0] pv;
        logic [31:0] pd;
        logic pe;
        m_last = 3; m_owner = 0; m_bytes = 0; m_start_cyc = 0; m_fin_mark = 0;
        m_fly = 0; m_en_drop = 0; m_done_prev = 0; m_byte = '0;
        forever begin
            @(posedge clk);
            pv = reqValid; pd = reqData; pe = enable;
            @(negedge clk);
            if (!rstN) begin
                m_last = 3; m_fly = 0; m_en_drop = 0; m_done_prev = 0; m_bytes = 0;
            end else begin
                check("uTxEn", uTxEn, enable);
                cont = BURST && m_done_prev && pe && bit_of(pv, m_owner) && m_bytes < MAXB;
                if (reqReady != 0) begin
                    e = cont ? m_owner : (m_done_prev || m_fly || !pe) ? -1 : rr(pv, m_last);
                    check("ready_onehot", reqReady, e < 0 ? 4'b0 : 4'b1 << e);
                    if (e >= 0) begin
                        check("ready_grant", grantId, e);
                        check("ready_byte", uTxIn, byte_of(pd, e));
                    end
                    m_owner = e >= 0 ? e : int'(grantId);
                    m_byte = byte_of(pd, m_owner);
                    m_bytes = cont ? m_bytes + 1 : 1;
                    m_fly = 1; m_en_drop = 0; m_start_cyc = 0; m_fin_mark = uart_fin_cnt;
                end else if (cont) begin
                    check("burst_ready", reqReady, 4'b1 << m_owner);
                end
                if (uTxStart) begin
                    check("start_in_frame", m_fly, 1);
                    check("start_byte", uTxIn, m_byte);
                    check("start_grant", grantId, m_owner);
                    m_start_cyc++;
                end
                if (m_fly && !pe) m_en_drop = 1;
                if (reqDone != 0) begin
                    check("done_onehot", reqDone, m_fly ? 4'b1 << m_owner : 4'b0);
                    check("done_after_uart", uart_fin_cnt > m_fin_mark, 1);
                    check("done_start_low", uTxStart, 0);
                    m_last = m_owner; m_fly = 0;
                end
                if (errPulse) begin
                    err_seen++;
                    check("err_in_frame", m_fly, 1);
                    check("err_start_low", uTxStart, 0);
                    if (!m_en_drop) check("timeout_len", m_start_cyc, TIMEOUT);
                    m_last = m_owner; m_fly = 0;
                end
                m_done_prev = reqDone != 0;
            end
        end
    end

    task automatic wait_ev(input int sel, input int budget, input string nm, output int cyc, output logic [3:0] val);
        val = '0;
        cyc = 0;
        while (cyc < budget && val == 0) begin
            @(negedge clk);
            cyc++;
            val = sel == 0 ? reqReady : sel == 1 ? reqDone : {3'b000, errPulse};
        end
        if (val == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no event within %0d cycles", nm, budget);
        end
    endtask

    task automatic do_reset();
        #1 rstN = 1'b0;
        repeat (2) @(negedge clk);
        #1 rstN = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int cyc, quiet, e0;
        logic [3:0] v;
        logic [7:0] bytes_by[4];
`ifdef UART_ARB_BURST_EN
        int exp_idx[5] = '{0, 0, 1, 1, 2};
`else
        int exp_idx[5] = '{0, 1, 2, 3, 0};
`endif
        bytes_by = '{8'd24, 8'd19, 8'd25, 8'd91};

        @(negedge clk);
        check("rst_start", uTxStart, 0);
        check("rst_txin", uTxIn, 0);
        check("rst_ready", reqReady, 0);
        check("rst_done", reqDone, 0);
        check("rst_err", errPulse, 0);
        check("rst_grant", grantId, 0);
        check("rst_en", uTxEn, 0);
        #1 rstN = 1'b1;
        @(negedge clk);

        // Single requester 0, byte 30.
        #1 enable = 1'b1; reqValid = 4'b0001; reqData = 32'd30;
        wait_ev(0, 5, "t1_ready", cyc, v);
        check("t1_ready_lat", cyc, 1);
        check("t1_ready", v, 4'b0001);
        check("t1_txin", uTxIn, 30);
        check("t1_start", uTxStart, 1);
        #1 reqValid = 4'b0000;
        wait_ev(1, 60, "t1_done", cyc, v);
        check("t1_done", v, 4'b0001);
        check("t1_grant", grantId, 0);

        // All four valid: strict rotation from requester 0.
        do_reset();
        #1 reqValid = 4'b1111; reqData = {8'd91, 8'd25, 8'd19, 8'd24};
        for (int i = 0; i < 5; i++) begin
            wait_ev(0, 10, "t2_ready", cyc, v);
            check("t2_txin", uTxIn, bytes_by[exp_idx[i]]);
            wait_ev(1, 60, "t2_done", cyc, v);
            check("t2_done", v, 4'b1 << exp_idx[i]);
        end
        #1 reqValid = 4'b0100; reqData[23:16] = 8'd255;

        // Only requester 2: granted on every arbitration.
        e0 = err_seen;
        for (int i = 0; i < 3; i++) begin
            wait_ev(0, 10, "t3_ready", cyc, v);
            check("t3_ready", v, 4'b0100);
            check("t3_txin", uTxIn, 255);
            wait_ev(1, 60, "t3_done", cyc, v);
            check("t3_done", v, 4'b0100);
        end
        #1 reqValid = 4'b0000;
        check("t3_no_err", err_seen - e0, 0);
        repeat (4) @(negedge clk);

        // Start timeout: Uart8 never goes busy.
        do_reset();
        #1 uart_never = 1'b1; reqValid = 4'b0011; reqData = {16'h0, 8'h22, 8'h11};
        wait_ev(0, 5, "t4_ready", cyc, v);
        check("t4_ready", v, 4'b0001);
        wait_ev(2, 40, "t4_err", cyc, v);
        check("t4_err_lat", cyc, TIMEOUT);
        check("t4_start_low", uTxStart, 0);
        check("t4_no_done", reqDone, 0);
        #1 uart_never = 1'b0;
        wait_ev(0, 5, "t4_next", cyc, v);
        check("t4_next_lat", cyc, 1);
        check("t4_next", v, 4'b0010);
        check("t4_next_txin", uTxIn, 8'h22);
        #1 reqValid = 4'b0000;
        wait_ev(1, 60, "t4_done", cyc, v);
        check("t4_done", v, 4'b0010);
        repeat (4) @(negedge clk);

        // Enable drop mid-frame, then resume after the aborted owner.
        #1 reqValid = 4'b0101; reqData = {8'h0, 8'h5A, 8'h0, 8'hA5};
        wait_ev(0, 5, "t5_ready", cyc, v);
        check("t5_ready", v, 4'b0100);
        repeat (6) @(negedge clk);
        #1 enable = 1'b0;
        #1 check("t5_en_same", uTxEn, 0);
        wait_ev(2, 3, "t5_err", cyc, v);
        check("t5_err_lat", cyc, 1);
        check("t5_no_done", reqDone, 0);
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (reqDone != 0 || reqReady != 0) quiet++;
        end
        check("t5_quiet", quiet, 0);
        #1 enable = 1'b1;
        wait_ev(0, 5, "t5_resume", cyc, v);
        check("t5_resume", v, 4'b0001);
        check("t5_resume_txin", uTxIn, 8'hA5);
        #1 reqValid = 4'b0000;
        wait_ev(1, 60, "t5_done", cyc, v);
        check("t5_done", v, 4'b0001);

`ifdef UART_ARB_BURST_EN
        // Bursts of two between requesters 0 and 1.
        begin
            int bexp[6] = '{0, 0, 1, 1, 0, 0};
            do_reset();
            #1 reqValid = 4'b0011; reqData = {16'h0, 8'h0B, 8'h0A};
            for (int i = 0; i < 6; i++) begin
                wait_ev(0, 10, "t6_ready", cyc, v);
                check("t6_owner", grantId, bexp[i]);
                wait_ev(1, 60, "t6_done", cyc, v);
            end
            #1 reqValid = 4'b0000;
        end
`endif
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
